// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART receiver.
//   rx_state_e   : receiver FSM states
//   DATA_BITS    : payload bits per frame
//   IDLE_LEVEL   : line level when no frame is in flight
//   clks_per_bit : clock ticks per serial bit (integer-truncated)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync -- two-flop synchroniser for an asynchronous input.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset; both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronised output (2 clk latency)
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_recv.sv
// uart_recv -- UART receiver, 8N1 (8E1 when UART_RECV_PARITY_EN is defined).
//   clk           : system clock, posedge
//   rst_n         : asynchronous active-low reset
//   rx            : serial line, asynchronous to clk, idle high
//   data          : last correctly received byte (held across errors)
//   data_valid    : one-cycle strobe, data is new
//   framing_error : one-cycle strobe, stop bit sampled low
//   parity_error  : one-cycle strobe, even-parity mismatch (0 unless
//                   UART_RECV_PARITY_EN is defined)
//   busy          : high whenever the receiver is not idle
// Bit period is clkFreq/baudRate clocks and must be at least 4.
module uart_recv
  import uart_pkg::*;
#(
  parameter int baudRate = 9600,
  parameter int clkFreq  = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       framing_error,
  output logic       parity_error,
  output logic       busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(clkFreq, baudRate);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int IW           = $clog2(DATA_BITS);

  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_TICK = CW'(HALF_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

  logic rx_s;

  uart_sync #(.RESET_VAL(IDLE_LEVEL)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  rx_state_e              state_reg, state_next;
  logic [CW-1:0]          count_reg, count_next;
  logic [IW-1:0]          idx_reg, idx_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic [DATA_BITS-1:0]   data_reg, data_next;
  logic                   dv_reg, dv_next;
  logic                   fe_reg, fe_next;
`ifdef UART_RECV_PARITY_EN
  logic                   pe_reg, pe_next;
  logic                   par_bad_reg, par_bad_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      idx_reg     <= '0;
      shift_reg   <= '0;
      data_reg    <= '0;
      dv_reg      <= 1'b0;
      fe_reg      <= 1'b0;
`ifdef UART_RECV_PARITY_EN
      pe_reg      <= 1'b0;
      par_bad_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      idx_reg     <= idx_next;
      shift_reg   <= shift_next;
      data_reg    <= data_next;
      dv_reg      <= dv_next;
      fe_reg      <= fe_next;
`ifdef UART_RECV_PARITY_EN
      pe_reg      <= pe_next;
      par_bad_reg <= par_bad_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    // Free-running tick counter outside IDLE; cleared on every transition
    // and bit boundary below. Wrapping while parked in BREAK is harmless.
    count_next = (state_reg == IDLE) ? '0 : count_reg + 1'b1;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    dv_next    = 1'b0;
    fe_next    = 1'b0;
`ifdef UART_RECV_PARITY_EN
    pe_next      = 1'b0;
    par_bad_next = par_bad_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (rx_s != IDLE_LEVEL) state_next = START;
      end

      START: begin
        // Re-check the line half a bit in: a still-low line is a real start
        // bit, anything else was a glitch and is dropped silently.
        if (count_reg == HALF_TICK) begin
          count_next = '0;
          if (rx_s != IDLE_LEVEL) begin
            state_next = DATA;
            idx_next   = '0;
`ifdef UART_RECV_PARITY_EN
            par_bad_next = 1'b0;
`endif
          end else begin
            state_next = IDLE;
          end
        end
      end

      DATA: begin
        // Counting a full bit from mid start-bit lands every sample mid-bit.
        if (count_reg == LAST_TICK) begin
          count_next          = '0;
          shift_next[idx_reg] = rx_s;
          idx_next            = idx_reg + 1'b1;
          if (idx_reg == LAST_IDX) begin
`ifdef UART_RECV_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end

`ifdef UART_RECV_PARITY_EN
      PARITY: begin
        if (count_reg == LAST_TICK) begin
          count_next   = '0;
          par_bad_next = rx_s ^ (^shift_reg);
          state_next   = STOP;
        end
      end
`endif

      STOP: begin
        // Leaving at the stop-bit midpoint gives half a bit of slack to catch
        // the next start edge of a back-to-back frame.
        if (count_reg == LAST_TICK) begin
          count_next = '0;
          if (rx_s == IDLE_LEVEL) begin
            state_next = IDLE;
`ifdef UART_RECV_PARITY_EN
            if (par_bad_reg) begin
              pe_next = 1'b1;
            end else begin
              dv_next   = 1'b1;
              data_next = shift_reg;
            end
`else
            dv_next   = 1'b1;
            data_next = shift_reg;
`endif
          end else begin
            // Framing error wins over parity; park until the line goes idle
            // so a held-low line reports only once.
            fe_next    = 1'b1;
            state_next = BREAK;
          end
        end
      end

      BREAK: begin
        if (rx_s == IDLE_LEVEL) begin
          state_next = IDLE;
          count_next = '0;
        end
      end

      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  assign data          = data_reg;
  assign data_valid    = dv_reg;
  assign framing_error = fe_reg;
  assign busy          = (state_reg != IDLE);
`ifdef UART_RECV_PARITY_EN
  assign parity_error  = pe_reg;
`else
  assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv -- directed bench for uart_recv at CLKS_PER_BIT=10.
// Define UART_RECV_PARITY_EN for both bench and RTL to exercise 8E1.
module tb_uart_recv;

  localparam int CPB = 10;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_error;
  logic       parity_error;
  logic       busy;

  uart_recv #(
    .baudRate (10_000_000),
    .clkFreq  (100_000_000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .data          (data),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .parity_error  (parity_error),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Strobe bookkeeping, sampled on the falling edge.
  int         dv_cnt = 0;
  int         fe_cnt = 0;
  int         pe_cnt = 0;
  int         busy_seen = 0;
  logic [7:0] dv_q[$];

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt++;
      dv_q.push_back(data);
    end
    if (framing_error) fe_cnt++;
    if (parity_error) pe_cnt++;
    if (busy) busy_seen = 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
  endtask

`ifdef UART_RECV_PARITY_EN
  task automatic send_byte_par(input logic [7:0] b, input logic par_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par_bit);
    send_bit(1'b1);
  endtask
`endif

  // Advance n falling edges, then step off the edge to sample.
  task automatic wait_sample(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  int dv0, fe0, pe0;

  initial begin
    rx    = 1'b1;
    rst_n = 1'b0;
    wait_sample(3);
    check("rst_data", data, 8'h00);
    check("rst_dv", data_valid, 1'b0);
    check("rst_fe", framing_error, 1'b0);
    check("rst_pe", parity_error, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    wait_sample(5);

`ifndef UART_RECV_PARITY_EN
    // 1: single frame 0xA5
    dv0 = dv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
    send_byte(8'hA5, 1'b1);
    wait_sample(5);
    $display("txn A5 8N1: dv=%0d data=%h", dv_cnt - dv0, data);
    check("a5_dv_cnt", dv_cnt - dv0, 1);
    check("a5_data", data, 8'hA5);
    check("a5_fe_cnt", fe_cnt - fe0, 0);
    check("a5_pe_cnt", pe_cnt - pe0, 0);
    check("a5_busy", busy, 1'b0);

    // 2: 0x00 then 0xFF with no idle gap
    dv0 = dv_cnt;
    dv_q.delete();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    wait_sample(5);
    $display("txn 00,FF back-to-back: dv=%0d", dv_cnt - dv0);
    check("b2b_dv_cnt", dv_cnt - dv0, 2);
    check("b2b_first", (dv_q.size() > 0) ? dv_q[0] : 8'hxx, 8'h00);
    check("b2b_second", (dv_q.size() > 1) ? dv_q[1] : 8'hxx, 8'hFF);

    // 3: 0x3C with low stop bit, line held low, then released
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_byte(8'h3C, 1'b0);
    wait_sample(50);
    $display("txn 3C bad stop: fe=%0d dv=%0d data=%h", fe_cnt - fe0, dv_cnt - dv0, data);
    check("brk_fe_cnt", fe_cnt - fe0, 1);
    check("brk_dv_cnt", dv_cnt - dv0, 0);
    check("brk_data", data, 8'hFF);
    check("brk_busy_held", busy, 1'b1);
    rx = 1'b1;
    wait_sample(6);
    check("brk_busy_rel", busy, 1'b0);

    // 4: 3-clk glitch while idle
    dv0 = dv_cnt; fe0 = fe_cnt;
    busy_seen = 0;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    wait_sample(20);
    $display("txn glitch 3clk: busy_seen=%0d dv=%0d fe=%0d", busy_seen, dv_cnt - dv0, fe_cnt - fe0);
    check("gl_busy_seen", busy_seen, 1);
    check("gl_busy", busy, 1'b0);
    check("gl_dv_cnt", dv_cnt - dv0, 0);
    check("gl_fe_cnt", fe_cnt - fe0, 0);
`endif

    // 5: reset during bit 4, then a clean 0x5A
    dv0 = dv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_sample(1);
    check("ra_data", data, 8'h00);
    check("ra_busy", busy, 1'b0);
    wait_sample(20);
`ifdef UART_RECV_PARITY_EN
    send_byte_par(8'h5A, 1'b0);
`else
    send_byte(8'h5A, 1'b1);
`endif
    wait_sample(5);
    $display("txn reset-abort then 5A: dv=%0d data=%h", dv_cnt - dv0, data);
    check("ra_dv_cnt", dv_cnt - dv0, 1);
    check("ra_data_5a", data, 8'h5A);
    check("ra_err_cnt", (fe_cnt - fe0) + (pe_cnt - pe0), 0);

`ifdef UART_RECV_PARITY_EN
    // 6: 0x07 with wrong parity, then correct parity
    dv0 = dv_cnt; pe0 = pe_cnt;
    send_byte_par(8'h07, 1'b0);
    wait_sample(5);
    $display("txn 07 bad parity: pe=%0d dv=%0d data=%h", pe_cnt - pe0, dv_cnt - dv0, data);
    check("par_bad_pe", pe_cnt - pe0, 1);
    check("par_bad_dv", dv_cnt - dv0, 0);
    check("par_bad_data", data, 8'h5A);
    dv0 = dv_cnt; pe0 = pe_cnt;
    send_byte_par(8'h07, 1'b1);
    wait_sample(5);
    $display("txn 07 good parity: pe=%0d dv=%0d data=%h", pe_cnt - pe0, dv_cnt - dv0, data);
    check("par_ok_pe", pe_cnt - pe0, 0);
    check("par_ok_dv", dv_cnt - dv0, 1);
    check("par_ok_data", data, 8'h07);
    check("par_ok_busy", busy, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
